id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the execute ALU.
- Captures decoded instructions from the decode stage and presents the ALU's operands A/B, its 10-bit funct7+funct3 op code, and bookkeeping fields to the execute stage.
- Applies EX/MEM and MEM/WB operand forwarding, detects load-use hazards and inserts bubbles, honours flush and downstream hold.
- Keeps held operands fresh across writebacks.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  decode stage presents an instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_addr, id_rs2_addr  in  REGW  source registers
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_imm  in  XLEN  sign-extended immediate
- id_use_imm  in  1  B operand = imm
- id_use_pc  in  1  A operand = pc
- id_alu_op  in  10  {funct7, funct3}
- id_rd  in  REGW  destination register
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- flush  in  1  squash the instruction being captured
- ex_hold  in  1  execute cannot accept; freeze the register
- exm_rd  in  REGW  EX/MEM destination register
- exm_reg_write  in  1  EX/MEM writes rd
- exm_result  in  XLEN  EX/MEM ALU result
- wb_rd  in  REGW  MEM/WB destination register
- wb_reg_write  in  1  MEM/WB writes rd
- wb_data  in  XLEN  MEM/WB writeback value
- stall_out  out  1  decode/fetch must hold
- ex_valid  out  1  registered instruction valid
- alu_a, alu_b  out  XLEN  operands to the ALU
- alu_op  out  10  registered op
- ex_store_data  out  XLEN  forwarded rs2 value
- ex_pc  out  XLEN  registered PC
- ex_rd  out  REGW  registered destination
- ex_reg_write  out  1  registered write enable, gated by ex_valid
- ex_mem_read  out  1  registered load flag, gated by ex_valid

Behaviour:
- Reset, asynchronous:
  - All registered fields are 0.
  - ex_valid=0, ex_reg_write=0, ex_mem_read=0, alu_op=0, ex_pc=0, ex_rd=0.
  - alu_a/alu_b/ex_store_data are therefore 0.
  - stall_out=0 while rst is asserted.
- Load-use hazard, combinational:
  - luse = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_uses_rs1 & id_rs1_addr==ex_rd) | (id_uses_rs2 & id_rs2_addr==ex_rd)).
- stall_out = !flush & (ex_hold | luse).
- Register update at posedge; first matching row wins:
  - flush: ex_valid<=0 and other fields don't-care. This overrides hold (a squashed instruction is dropped even if execute is held).
  - ex_hold: all fields keep their values, except the stored rs1/rs2 data. If wb_reg_write & wb_rd!=0 & wb_rd==stored rsN_addr, stored rsN data<=wb_data. This prevents losing a retiring producer.
  - luse: ex_valid<=0 (bubble). The decode instruction is retried next cycle.
  - otherwise: capture all id_* fields, with ex_valid<=id_valid.
- Forwarding (combinational on registered fields), per operand N in {rs1, rs2}; first match wins:
  - rsN_addr==0 -> stored data; x0 is never forwarded.
  - exm_reg_write & exm_rd==rsN_addr -> exm_result.
  - wb_reg_write & wb_rd==rsN_addr -> wb_data.
  - else -> stored data.
- Operand and output selection:
  - alu_a = ex_use_pc ? ex_pc : fwd_rs1.
  - alu_b = ex_use_imm ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- Latency: an instruction accepted at edge k drives alu_a/alu_b in cycle k (same cycle as the register update), one cycle after id presentation.
- Invalid slot: outputs still reflect stored fields. ex_reg_write and ex_mem_read are forced 0 when ex_valid=0.
- Reset mid-stall clears immediately. No instruction is replayed by this block; stall_out drops, and recovery is the fetch stage's job.

Test Plan:
- Back-to-back dependency:
  - Stimulus: add x3,x1,x2 then sub x4,x3,x1, with exm_rd=3, exm_result=0x10 when the sub is in EX; stored rs1 data stale (0x0).
  - Response: alu_a=0x10, alu_op=0x100, stall_out=0.
- Load-use:
  - Stimulus: lw x5 registered (ex_mem_read=1, ex_rd=5); id presents add x6,x5,x0.
  - Response: stall_out=1 for exactly one cycle, next cycle ex_valid=0, following cycle add captured.
  - Repeat with id_uses_rs2=0 and only rs2==5: no stall.
- x0 and priority:
  - Stimulus (x0): rs1=0 with exm_rd=0, exm_reg_write=1, exm_result=0xDEAD.
  - Response: alu_a=stored 0.
  - Stimulus (priority): rs2=7, exm_rd=wb_rd=7, exm_result=1, wb_data=2.
  - Response: ex_store_data=1.
- Hold with writeback:
  - Stimulus: assert ex_hold 3 cycles with stored rs1=9. During cycle 2 present wb_rd=9, wb_data=0x55; exm never matches.
  - Response: all fields frozen, stall_out=1, alu_a=0x55 after hold releases.
- Flush vs hold and load-use:
  - Stimulus: flush=1 together with ex_hold=1 and luse conditions.
  - Response: stall_out=0 and ex_valid=0 next cycle.
- Async reset:
  - Stimulus: assert rst mid-cycle while ex_valid=1.
  - Response: ex_valid, ex_reg_write, alu_a fall to 0 before the next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instructions, forwards EX/MEM and MEM/WB
// results into the ALU operands, and inserts bubbles on load-use hazards.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [REGW-1:0] id_rs1_addr,
  input  logic [REGW-1:0] id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic            id_use_pc,
  input  logic [9:0]      id_alu_op,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            flush,
  input  logic            ex_hold,
  input  logic [REGW-1:0] exm_rd,
  input  logic            exm_reg_write,
  input  logic [XLEN-1:0] exm_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_out,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [9:0]      alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [REGW-1:0] rs1_addr_q;
  logic [REGW-1:0] rs2_addr_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic            use_imm_q;
  logic            use_pc_q;
  logic [9:0]      op_q;
  logic [REGW-1:0] rd_q;
  logic            reg_write_q;
  logic            mem_read_q;

  logic            luse;
  logic            wb_hits_rs1;
  logic            wb_hits_rs2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Handshake: the decode stage may advance only in a cycle where stall_out is low;
  // ex_hold from execute freezes this register, and flush always wins over both.
  assign luse = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                ((id_uses_rs1 && (id_rs1_addr == rd_q)) ||
                 (id_uses_rs2 && (id_rs2_addr == rd_q)));

  assign stall_out = !rst && !flush && (ex_hold || luse);

  assign wb_hits_rs1 = wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_addr_q);
  assign wb_hits_rs2 = wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      use_pc_q    <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (ex_hold) begin
      // A producer retiring while we are frozen would otherwise be lost to forwarding.
      if (wb_hits_rs1) rs1_data_q <= wb_data;
      if (wb_hits_rs2) rs2_data_q <= wb_data;
    end else if (luse) begin
      valid_q <= 1'b0;
    end else begin
      valid_q     <= id_valid;
      pc_q        <= id_pc;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      use_imm_q   <= id_use_imm;
      use_pc_q    <= id_use_pc;
      op_q        <= id_alu_op;
      rd_q        <= id_rd;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
    end
  end

  // x0 always reads its stored value; EX/MEM is younger than MEM/WB so it wins.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (rs1_addr_q != '0) begin
      if (exm_reg_write && (exm_rd == rs1_addr_q))    fwd_rs1 = exm_result;
      else if (wb_reg_write && (wb_rd == rs1_addr_q)) fwd_rs1 = wb_data;
    end
  end

  always_comb begin
    fwd_rs2 = rs2_data_q;
    if (rs2_addr_q != '0) begin
      if (exm_reg_write && (exm_rd == rs2_addr_q))    fwd_rs2 = exm_result;
      else if (wb_reg_write && (wb_rd == rs2_addr_q)) fwd_rs2 = wb_data;
    end
  end

  assign ex_valid      = valid_q;
  assign alu_a         = use_pc_q ? pc_q : fwd_rs1;
  assign alu_b         = use_imm_q ? imm_q : fwd_rs2;
  assign alu_op        = op_q;
  assign ex_store_data = fwd_rs2;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = valid_q && reg_write_q;
  assign ex_mem_read   = valid_q && mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed pipeline scenarios followed by random traffic,
// all compared against an instruction-slot reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic [31:0] id_rs1_data, id_rs2_data;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_imm;
  logic        id_use_imm, id_use_pc;
  logic [9:0]  id_alu_op;
  logic [4:0]  id_rd;
  logic        id_reg_write, id_mem_read;
  logic        flush, ex_hold;
  logic [4:0]  exm_rd;
  logic        exm_reg_write;
  logic [31:0] exm_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        stall_out, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [9:0]  alu_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
    .id_alu_op(id_alu_op), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .ex_hold(ex_hold),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .stall_out(stall_out), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction occupying the execute slot.
  typedef struct {
    logic        valid;
    logic        known;  // 0 once a flush/bubble leaves the stored fields unspecified
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic        use_imm, use_pc, rw, mr;
    logic [9:0]  op;
  } slot_t;

  slot_t m;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return d;
    if (exm_reg_write && exm_rd == a) return exm_result;
    if (wb_reg_write && wb_rd == a) return wb_data;
    return d;
  endfunction

  function automatic logic model_luse();
    return m.valid && m.mr && m.rd != 5'd0 && id_valid &&
           ((id_uses_rs1 && id_rs1_addr == m.rd) || (id_uses_rs2 && id_rs2_addr == m.rd));
  endfunction

  task automatic model_reset();
    m = '{valid: 1'b0, known: 1'b1, pc: 32'd0, rs1d: 32'd0, rs2d: 32'd0, imm: 32'd0,
          rs1a: 5'd0, rs2a: 5'd0, rd: 5'd0, use_imm: 1'b0, use_pc: 1'b0, rw: 1'b0,
          mr: 1'b0, op: 10'd0};
  endtask

  task automatic model_clock();
    if (flush) begin
      m.valid = 1'b0;
      m.known = 1'b0;
    end else if (ex_hold) begin
      if (wb_reg_write && wb_rd != 5'd0 && wb_rd == m.rs1a) m.rs1d = wb_data;
      if (wb_reg_write && wb_rd != 5'd0 && wb_rd == m.rs2a) m.rs2d = wb_data;
    end else if (model_luse()) begin
      m.valid = 1'b0;
      m.known = 1'b0;
    end else begin
      m = '{valid: id_valid, known: 1'b1, pc: id_pc, rs1d: id_rs1_data, rs2d: id_rs2_data,
            imm: id_imm, rs1a: id_rs1_addr, rs2a: id_rs2_addr, rd: id_rd,
            use_imm: id_use_imm, use_pc: id_use_pc, rw: id_reg_write, mr: id_mem_read,
            op: id_alu_op};
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] f1, f2;
    check({tag, ".stall"}, 32'(stall_out), 32'(!rst && !flush && (ex_hold || model_luse())));
    check({tag, ".valid"}, 32'(ex_valid), 32'(m.valid));
    check({tag, ".reg_write"}, 32'(ex_reg_write), 32'(m.valid && m.rw));
    check({tag, ".mem_read"}, 32'(ex_mem_read), 32'(m.valid && m.mr));
    if (m.known) begin
      f1 = operand(m.rs1a, m.rs1d);
      f2 = operand(m.rs2a, m.rs2d);
      check({tag, ".alu_a"}, alu_a, m.use_pc ? m.pc : f1);
      check({tag, ".alu_b"}, alu_b, m.use_imm ? m.imm : f2);
      check({tag, ".store"}, ex_store_data, f2);
      check({tag, ".op"}, 32'(alu_op), 32'(m.op));
      check({tag, ".pc"}, ex_pc, m.pc);
      check({tag, ".rd"}, 32'(ex_rd), 32'(m.rd));
    end
  endtask

  // Settle the inputs driven after the falling edge, then compare.
  task automatic settle(input string tag);
    #1;
    check_all(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0;
    id_rs2_data = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_imm = 0; id_use_imm = 0;
    id_use_pc = 0; id_alu_op = 0; id_rd = 0; id_reg_write = 0; id_mem_read = 0;
    flush = 0; ex_hold = 0; exm_rd = 0; exm_reg_write = 0; exm_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0;
  endtask

  task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                       input logic [4:0] rs2, input logic [31:0] d2, input logic [9:0] op,
                       input logic [4:0] rd, input logic mr);
    id_valid = 1; id_pc = pc; id_rs1_addr = rs1; id_rs1_data = d1; id_uses_rs1 = 1;
    id_rs2_addr = rs2; id_rs2_data = d2; id_uses_rs2 = 1; id_alu_op = op; id_rd = rd;
    id_reg_write = 1; id_mem_read = mr; id_use_imm = 0; id_use_pc = 0; id_imm = 0;
  endtask

  initial begin
    idle_bus();
    rst = 1;
    ex_hold = 1;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    ex_hold = 0;
    @(negedge clk);
    rst = 0;

    // Back-to-back dependency: add x3,x1,x2 ; sub x4,x3,x1
    instr(32'h1000, 5'd1, 32'h0, 5'd2, 32'h5, 10'h000, 5'd3, 1'b0);
    settle("add");
    tick();
    instr(32'h1004, 5'd3, 32'h0, 5'd1, 32'h0, 10'h100, 5'd4, 1'b0);
    settle("sub_id");
    tick();
    idle_bus();
    exm_rd = 5'd3; exm_reg_write = 1; exm_result = 32'h10;
    settle("sub_ex");
    check("dep.alu_a", alu_a, 32'h10);
    check("dep.alu_op", 32'(alu_op), 32'h100);
    check("dep.stall", 32'(stall_out), 32'd0);
    tick();

    // Load-use: lw x5 then add x6,x5,x0
    idle_bus();
    instr(32'h2000, 5'd1, 32'h40, 5'd0, 32'h0, 10'h000, 5'd5, 1'b1);
    tick();
    instr(32'h2004, 5'd5, 32'h0, 5'd0, 32'h0, 10'h000, 5'd6, 1'b0);
    settle("luse1");
    check("luse.stall_on", 32'(stall_out), 32'd1);
    tick();
    settle("luse2");
    check("luse.bubble", 32'(ex_valid), 32'd0);
    check("luse.stall_off", 32'(stall_out), 32'd0);
    tick();
    idle_bus();
    settle("luse3");
    check("luse.captured", 32'(ex_rd), 32'd6);
    tick();
    instr(32'h2008, 5'd1, 32'h40, 5'd0, 32'h0, 10'h000, 5'd5, 1'b1);
    tick();
    instr(32'h200c, 5'd1, 32'h7, 5'd5, 32'h0, 10'h000, 5'd6, 1'b0);
    id_uses_rs2 = 0;
    settle("nouse");
    check("nouse.stall", 32'(stall_out), 32'd0);
    tick();

    // x0 never forwarded; EX/MEM beats MEM/WB
    instr(32'h3000, 5'd0, 32'h0, 5'd7, 32'h33, 10'h007, 5'd8, 1'b0);
    tick();
    idle_bus();
    exm_rd = 5'd0; exm_reg_write = 1; exm_result = 32'hDEAD;
    settle("x0");
    check("x0.alu_a", alu_a, 32'h0);
    exm_rd = 5'd7; exm_result = 32'h1; wb_rd = 5'd7; wb_reg_write = 1; wb_data = 32'h2;
    settle("prio");
    check("prio.store", ex_store_data, 32'h1);
    tick();

    // Hold for three cycles with a writeback to stored rs1 in the middle
    idle_bus();
    instr(32'h4000, 5'd9, 32'h9, 5'd2, 32'h2, 10'h005, 5'd10, 1'b0);
    tick();
    instr(32'h4004, 5'd11, 32'h1, 5'd12, 32'h2, 10'h001, 5'd13, 1'b0);
    ex_hold = 1;
    settle("hold1");
    check("hold.stall", 32'(stall_out), 32'd1);
    tick();
    wb_rd = 5'd9; wb_reg_write = 1; wb_data = 32'h55;
    settle("hold2");
    tick();
    wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    settle("hold3");
    check("hold.alu_a", alu_a, 32'h55);
    check("hold.rd", 32'(ex_rd), 32'd10);
    tick();
    ex_hold = 0;
    settle("hold_rel");
    check("release.alu_a", alu_a, 32'h55);
    tick();

    // Flush overrides hold and load-use
    idle_bus();
    instr(32'h5000, 5'd1, 32'h0, 5'd0, 32'h0, 10'h000, 5'd5, 1'b1);
    tick();
    instr(32'h5004, 5'd5, 32'h0, 5'd0, 32'h0, 10'h000, 5'd6, 1'b0);
    ex_hold = 1; flush = 1;
    settle("flush");
    check("flush.stall", 32'(stall_out), 32'd0);
    tick();
    idle_bus();
    settle("flushed");
    check("flush.valid", 32'(ex_valid), 32'd0);

    // Asynchronous reset in the middle of a cycle
    instr(32'h6000, 5'd1, 32'h77, 5'd2, 32'h88, 10'h000, 5'd3, 1'b0);
    tick();
    idle_bus();
    id_valid = 1;
    ex_hold = 1;
    #2;
    rst = 1;
    model_reset();
    #1;
    check("arst.valid", 32'(ex_valid), 32'd0);
    check("arst.reg_write", 32'(ex_reg_write), 32'd0);
    check("arst.alu_a", alu_a, 32'd0);
    check_all("arst");
    @(negedge clk);
    rst = 0;
    ex_hold = 0;

    // Random traffic on a small register window so hazards and forwards are frequent
    for (int i = 0; i < 400; i++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_pc         = $urandom;
      id_rs1_addr   = 5'($urandom_range(0, 7));
      id_rs2_addr   = 5'($urandom_range(0, 7));
      id_rs1_data   = $urandom;
      id_rs2_data   = $urandom;
      id_uses_rs1   = 1'($urandom_range(0, 1));
      id_uses_rs2   = 1'($urandom_range(0, 1));
      id_imm        = $urandom;
      id_use_imm    = 1'($urandom_range(0, 1));
      id_use_pc     = ($urandom_range(0, 3) == 0);
      id_alu_op     = 10'($urandom);
      id_rd         = 5'($urandom_range(0, 7));
      id_reg_write  = 1'($urandom_range(0, 1));
      id_mem_read   = ($urandom_range(0, 2) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      ex_hold       = ($urandom_range(0, 4) == 0);
      exm_rd        = 5'($urandom_range(0, 7));
      exm_reg_write = 1'($urandom_range(0, 1));
      exm_result    = $urandom;
      wb_rd         = 5'($urandom_range(0, 7));
      wb_reg_write  = 1'($urandom_range(0, 1));
      wb_data       = $urandom;
      settle("rand");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
